// File: rtl/mte_block_unpacker_if.sv
// Stream bundle for the block unpacker: one 256-bit block input and one byte output stream.
// The slave modport is the unpacker; the master modport is the block source and byte sink.
interface mte_block_unpacker_if #(
  parameter int BLOCK_W = 256
);
  logic               blk_valid;
  logic               blk_ready;
  logic [BLOCK_W-1:0] blk_data;
  logic [5:0]         blk_len;
  logic               byte_valid;
  logic               byte_ready;
  logic [7:0]         byte_data;
  logic               byte_last;

  modport master (
    output blk_valid, blk_data, blk_len, byte_ready,
    input  blk_ready, byte_valid, byte_data, byte_last
  );

  modport slave (
    input  blk_valid, blk_data, blk_len, byte_ready,
    output blk_ready, byte_valid, byte_data, byte_last
  );
endinterface

// File: rtl/mte_block_unpacker.sv
// Splits an MTE result block into a byte stream, first character (top byte) first,
// dropping pad bytes beyond the valid length and counting completed blocks.
//
// state | meaning
// IDLE  | no block held, ready for a new block
// SEND  | block held in shift register, presenting its top byte
module mte_block_unpacker #(
  parameter int BLOCK_W = 256,
  parameter int CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mte_block_unpacker_if.slave  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     block_count
);
  localparam int NBYTES = BLOCK_W / 8;
  localparam logic [6:0] NB = 7'(NBYTES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  logic [BLOCK_W-1:0] shift_q;
  logic [6:0]         remaining;
  logic [6:0]         len_eff;
  logic [6:0]         len_ext;

  assign len_ext = {1'b0, bus.blk_len};
  assign len_eff = (bus.blk_len == 6'd0 || len_ext > NB) ? NB : len_ext;

  assign bus.byte_valid = (state == SEND);
  assign bus.byte_data  = shift_q[BLOCK_W-1 -: 8];
  assign bus.byte_last  = (state == SEND) && (remaining == 7'd1);
  assign busy           = (state == SEND);

  // Accepting during the final byte lets back-to-back blocks stream without a bubble.
  assign bus.blk_ready = (state == IDLE) ||
                         ((state == SEND) && (remaining == 7'd1) && bus.byte_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shift_q     <= '0;
      remaining   <= '0;
      block_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.blk_valid) begin
            shift_q   <= bus.blk_data;
            remaining <= len_eff;
            state     <= SEND;
          end
        end
        SEND: begin
          if (bus.byte_ready) begin
            if (remaining > 7'd1) begin
              shift_q   <= shift_q << 8;
              remaining <= remaining - 7'd1;
            end else begin
              block_count <= block_count + 1'b1;
              if (bus.blk_valid) begin
                shift_q   <= bus.blk_data;
                remaining <= len_eff;
              end else begin
                remaining <= '0;
                state     <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mte_block_unpacker.sv
// Bench for mte_block_unpacker: directed cases plus random traffic against a byte-queue model.
module tb_mte_block_unpacker;
  logic       clock = 1'b0;
  logic       reset_n;
  logic       busy;
  logic [3:0] block_count;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  int         exp_count;

  mte_block_unpacker_if #(.BLOCK_W(256)) bus ();

  mte_block_unpacker #(.BLOCK_W(256), .CNT_W(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .busy        (busy),
    .block_count (block_count)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int len_eff(input logic [5:0] l);
    return (l == 6'd0 || l > 6'd32) ? 32 : int'(l);
  endfunction

  task automatic push_block(input logic [255:0] d, input logic [5:0] l);
    int n;
    n = len_eff(l);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, d[255 - 8*i -: 8]});
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit bv, input logic [255:0] bd, input logic [5:0] bl,
                       input bit br, output bit blk_x, output bit byte_x);
    int sz;
    @(negedge clock);
    bus.blk_valid  = bv;
    bus.blk_data   = bd;
    bus.blk_len    = bl;
    bus.byte_ready = br;
    #1;
    sz = exp_q.size();
    chk_eq("byte_valid", bus.byte_valid, sz != 0);
    chk_eq("busy", busy, sz != 0);
    chk_eq("blk_ready", bus.blk_ready, (sz == 0) || (sz == 1 && br));
    chk_eq("block_count", block_count, exp_count % 16);
    if (sz != 0) begin
      chk_eq("byte_data", bus.byte_data, exp_q[0][7:0]);
      chk_eq("byte_last", bus.byte_last, exp_q[0][8]);
    end
    byte_x = (sz != 0) && br;
    blk_x  = bv && ((sz == 0) || (sz == 1 && br));
    if (byte_x) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) exp_count++;
    end
    if (blk_x) push_block(bd, bl);
  endtask

  task automatic drain(input int mode);
    bit bx, yx;
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cycle(1'b0, '0, 6'd0, (mode == 0) ? 1'b1 : (n % 3 == 0), bx, yx);
      n++;
    end
    if (exp_q.size() != 0) chk_eq("drain_timeout", n, 0);
    cycle(1'b0, '0, 6'd0, 1'b1, bx, yx);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n        = 1'b0;
    bus.blk_valid  = 1'b0;
    bus.blk_data   = '0;
    bus.blk_len    = '0;
    bus.byte_ready = 1'b0;
    exp_q.delete();
    exp_count = 0;
    @(negedge clock);
    #1;
    chk_eq("rst_byte_valid", bus.byte_valid, 0);
    chk_eq("rst_byte_data", bus.byte_data, 0);
    chk_eq("rst_byte_last", bus.byte_last, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_count", block_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  logic [255:0] alpha, hi_blk, rnd_blk, b2;
  bit           bx, yx;

  initial begin
    alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZ012345";
    hi_blk = {8'h48, 8'h69, 8'h21, 8'h0A, {28{8'h30}}};
    do_reset();

    // Full-length block with len 0 meaning 32.
    cycle(1'b1, alpha, 6'd0, 1'b1, bx, yx);
    chk_eq("t1_accept", bx, 1);
    drain(0);
    chk_eq("t1_count", block_count, 1);

    // Short block with pad, then an over-length clamp.
    cycle(1'b1, hi_blk, 6'd4, 1'b1, bx, yx);
    drain(0);
    rnd_blk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    cycle(1'b1, rnd_blk, 6'd40, 1'b1, bx, yx);
    drain(0);

    // Backpressure pattern 1,0,0,1,0,0...
    cycle(1'b1, alpha, 6'd0, 1'b1, bx, yx);
    drain(1);

    // Back-to-back 3-byte blocks.
    begin
      int acc_idx = -1;
      int nbytes  = 0;
      bit got2    = 0;
      b2 = {8'h61, 8'h62, 8'h63, 232'h0};
      cycle(1'b1, alpha, 6'd3, 1'b1, bx, yx);
      for (int i = 0; i < 6; i++) begin
        cycle(!got2, b2, 6'd3, 1'b1, bx, yx);
        if (bx && !got2) begin
          got2    = 1;
          acc_idx = i;
        end
        if (bus.byte_valid) nbytes++;
      end
      chk_eq("b2b_accept_idx", acc_idx, 2);
      chk_eq("b2b_bytes", nbytes, 6);
      drain(0);
    end

    // Reset in the middle of a block.
    cycle(1'b1, alpha, 6'd0, 1'b1, bx, yx);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 6'd0, 1'b1, bx, yx);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk_eq("midrst_valid", bus.byte_valid, 0);
    chk_eq("midrst_count", block_count, 0);
    exp_q.delete();
    exp_count = 0;
    @(negedge clock);
    reset_n = 1'b1;
    cycle(1'b1, {8'h5A, 248'h0}, 6'd1, 1'b1, bx, yx);
    drain(0);

    // Counter wrap with 16 single-byte blocks back to back.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, {8'(i), 248'h0}, 6'd1, 1'b1, bx, yx);
    drain(0);
    chk_eq("wrap_count", block_count, 0);

    // Random traffic with held-valid upstream.
    begin
      bit           pend = 0;
      logic [255:0] pd;
      logic [5:0]   pl;
      bit           vv = 0;
      for (int c = 0; c < 600; c++) begin
        if (!pend) begin
          pd   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
          pl   = 6'($urandom_range(0, 63));
          pend = 1;
          vv   = 0;
        end
        if (!vv) vv = ($urandom_range(0, 3) != 0);
        cycle(vv, pd, pl, ($urandom_range(0, 3) != 0), bx, yx);
        if (bx) pend = 0;
      end
      drain(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mte_block_unpacker.md
Name: mte_block_unpacker

Overview:
- Output-side converter for the MTE encrypt/decrypt datapath; the inverse of the stimulus-side byte packer.
- Accepts one 256-bit MTE result block (32 ASCII characters, first character in the top byte) with a valid-byte count.
- Emits the characters one byte per cycle over a valid/ready stream, first character first, so decrypted text can be reassembled and compared to the source file.
- Sits between MTE.OUT (plus scoreboard/queue logic) and a byte sink (file writer, UART, FIFO).

Parameters:
- BLOCK_W, 256, block width in bits; must be a multiple of 8.
- NBYTES, BLOCK_W/8 (32), bytes per block; derived, do not override.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clock  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- blk_valid  in  1  upstream block is valid.
- blk_ready  out  1  unpacker accepts a block this cycle.
- blk_data  in  BLOCK_W  block; byte 0 = blk_data[BLOCK_W-1 -: 8].
- blk_len  in  6  number of valid bytes, starting at byte 0; 0 means NBYTES.
- byte_valid  out  1  byte_data is valid.
- byte_ready  in  1  downstream accepts the byte.
- byte_data  out  8  current character.
- byte_last  out  1  current byte is the last valid byte of its block.
- busy  out  1  a block is held (state SEND).
- block_count  out  CNT_W  number of fully emitted blocks; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE.
  - byte_valid=0, byte_data=0, byte_last=0, busy=0, block_count=0.
  - Internal shift register and index cleared.
- Handshake rules:
  - A block transfers on a clock edge with blk_valid && blk_ready.
  - A byte transfers on a clock edge with byte_valid && byte_ready.
- Length normalisation:
  - len_eff = (blk_len==0 || blk_len>NBYTES) ? NBYTES : blk_len.
  - Values above 32 clamp to 32; no error is flagged.
- FSM states IDLE and SEND:
  - IDLE:
    - blk_ready=1, byte_valid=0.
    - On block transfer: load shift register, set remaining=len_eff, go to SEND.
  - SEND:
    - byte_valid=1.
    - byte_data = shift register top byte.
    - byte_last = (remaining==1).
    - On byte transfer with remaining>1: shift left by 8 and decrement remaining.
  - Last-byte transfer in SEND (remaining==1):
    - block_count increments.
    - If blk_valid is also high, blk_ready=1 in that same cycle. The new block loads and the state stays SEND, with no bubble.
    - Otherwise go to IDLE.
  - blk_ready = (state==IDLE) || (state==SEND && remaining==1 && byte_ready). The byte_ready-to-blk_ready path is combinational and intended.
- Latency and throughput:
  - The first byte is visible (byte_valid=1) the cycle after block acceptance.
  - With byte_ready held high: N bytes in N consecutive cycles.
  - Back-to-back blocks stream with zero idle cycles.
- Backpressure:
  - While byte_valid && !byte_ready, byte_data, byte_last and internal state hold stable.
  - blk_ready=0 in this condition.
- Bytes beyond len_eff are never emitted; pad characters are dropped.
- busy = (state==SEND).
- Reset asserted mid-block:
  - The block is discarded immediately and block_count clears.
  - No partial output after release.
  - The first cycle after release is IDLE with blk_ready=1.
- Simultaneous blk_valid while in SEND with remaining>1: the block is not accepted; upstream must hold it.

Test Plan:
1. Reset release, blk_data = ASCII "ABCDEFGHIJKLMNOPQRSTUVWXYZ012345", blk_len=0, byte_ready=1 -> 32 bytes 0x41..0x5A, then 0x30..0x35 on consecutive cycles. byte_last only on 0x35. block_count=1, then IDLE.
2. blk_data = "Hi!\n" in bytes 0..3 plus 28 pad '0' (0x30), blk_len=4 -> bytes 0x48, 0x69, 0x21, 0x0A. byte_last on 0x0A. No 0x30 emitted. blk_len=40 on a second block -> 32 bytes emitted.
3. Backpressure: byte_ready pattern 1,0,0,1,... during test 1 -> byte_data stable across stall cycles, no byte duplicated or lost, and blk_ready=0 while stalled.
4. Back-to-back: two blocks with blk_len=3 and blk_valid held high, byte_ready=1 -> 6 bytes in 6 consecutive cycles. The second block is accepted in the cycle the first block's byte 2 transfers. block_count=2.
5. Reset mid-block: assert reset_n=0 asynchronously after 10 bytes of a 32-byte block -> byte_valid=0 before the next edge and block_count=0. After release, a new block (blk_len=1, 0x5A) emits exactly 0x5A with byte_last=1.
6. Wrap: force 2^16 blocks (or CNT_W=4 with 16 blocks) -> block_count returns to 0 with no other effect.
